// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the five-stage datapath and its hazard/sequencing controller.
// master = datapath side (supplies stage fields), slave = controller side (drives controls).
interface pipeline_ctrl_if #(
  parameter int unsigned STALL_W = 16
);
  // Stage fields sampled from the datapath
  logic               ihit;
  logic               dhit;
  logic               mem_ren;
  logic               mem_wen;
  logic               ex_ren;
  logic [4:0]         ex_wreg;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_uses_rt;
  logic               redirect;
  logic               wb_halt;

  // Controls applied to the PC and pipeline registers at the next edge
  logic               pc_wen;
  logic               ifid_wen;
  logic               idex_wen;
  logic               exmem_wen;
  logic               memwb_wen;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic               memwb_flush;
  logic               imemREN;
  logic               halt;
  logic [STALL_W-1:0] stall_count;

  modport master (
    output ihit, dhit, mem_ren, mem_wen, ex_ren, ex_wreg, id_rs, id_rt,
           id_uses_rt, redirect, wb_halt,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           imemREN, halt, stall_count
  );

  modport slave (
    input  ihit, dhit, mem_ren, mem_wen, ex_ren, ex_wreg, id_rs, id_rt,
           id_uses_rt, redirect, wb_halt,
    output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           imemREN, halt, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: pipeline write-enables/flushes, shared memory
// port arbitration, halt latch and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int unsigned STALL_W = 16
) (
  input logic            CLK,
  input logic            RST,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               halt_q;
  logic [STALL_W-1:0] stall_q;

  logic dpend;
  logic luse;

  logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic imem_ren;

  assign dpend = bus.mem_ren | bus.mem_wen;

  // A load in EX whose destination is read by the instruction in ID
  assign luse = bus.ex_ren && (bus.ex_wreg != 5'd0) &&
                ((bus.ex_wreg == bus.id_rs) ||
                 (bus.id_uses_rt && (bus.ex_wreg == bus.id_rt)));

  // Mealy control decode; priority order inside RUN/DWAIT is significant
  always_comb begin
    state_d     = state_q;
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    idex_wen    = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    imem_ren    = 1'b0;

    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
    end else begin
      unique case (state_q)
        RUN, DWAIT: begin
          imem_ren = (state_q == RUN) && !dpend;
          if (bus.wb_halt) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = HALT;
          end else if (dpend && !bus.dhit) begin
            // Freeze upstream stages; a bubble drains into WB while data waits
            memwb_flush = 1'b1;
            state_d     = DWAIT;
          end else begin
            state_d = RUN;
            if (bus.redirect) begin
              pc_wen      = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              memwb_wen   = 1'b1;
            end else if (luse) begin
              idex_flush = 1'b1;
              exmem_wen  = 1'b1;
              memwb_wen  = 1'b1;
            end else if (!bus.ihit) begin
              ifid_flush = 1'b1;
              idex_wen   = 1'b1;
              exmem_wen  = 1'b1;
              memwb_wen  = 1'b1;
            end else begin
              pc_wen    = 1'b1;
              ifid_wen  = 1'b1;
              idex_wen  = 1'b1;
              exmem_wen = 1'b1;
              memwb_wen = 1'b1;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, halt flag and saturating stall counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == HALT);
      if ((state_q != HALT) && !pc_wen && (stall_q != {STALL_W{1'b1}})) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign bus.pc_wen      = pc_wen;
  assign bus.ifid_wen    = ifid_wen;
  assign bus.idex_wen    = idex_wen;
  assign bus.exmem_wen   = exmem_wen;
  assign bus.memwb_wen   = memwb_wen;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.imemREN     = imem_ren;
  assign bus.halt        = halt_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-scenario stimulus tables with a
// queue of expected controls, halt flag and stall count.
module tb_pipeline_ctrl;

  localparam int unsigned SW   = 16;
  localparam int unsigned SW_S = 4;

  typedef logic [9:0] ctrl_t;  // {pc,ifid,idex,exmem,memwb wen, ifid,idex,exmem,memwb flush, imemREN}

  localparam ctrl_t C_RST     = 10'b00000_1111_0;
  localparam ctrl_t C_RUN     = 10'b11111_0000_1;
  localparam ctrl_t C_LUSE    = 10'b00011_0100_1;
  localparam ctrl_t C_IMISS   = 10'b00111_1000_1;
  localparam ctrl_t C_IMISS_D = 10'b00111_1000_0;
  localparam ctrl_t C_DFRZ    = 10'b00000_0001_0;
  localparam ctrl_t C_DHIT    = 10'b11111_0000_0;
  localparam ctrl_t C_REDIR_D = 10'b10001_1110_0;
  localparam ctrl_t C_REDIR_R = 10'b10001_1110_1;
  localparam ctrl_t C_HFL_R   = 10'b00000_1110_1;
  localparam ctrl_t C_HFL_D   = 10'b00000_1110_0;
  localparam ctrl_t C_HALTED  = 10'b00000_0000_0;

  typedef struct {
    logic       rst, ihit, dhit, mren, mwen, exren;
    logic [4:0] wreg, rs, rt;
    logic       usert, redir, whalt;
    ctrl_t      c;
    logic       h;
  } step_t;

  typedef struct {
    ctrl_t         ctrl;
    logic          halt;
    logic [SW-1:0] cnt;
  } exp_t;

  logic CLK;
  logic RST;
  logic RST_S;

  pipeline_ctrl_if #(.STALL_W(SW))   bus ();
  pipeline_ctrl_if #(.STALL_W(SW_S)) bus_s ();

  pipeline_ctrl #(.STALL_W(SW))   dut   (.CLK(CLK), .RST(RST),   .bus(bus));
  pipeline_ctrl #(.STALL_W(SW_S)) dut_s (.CLK(CLK), .RST(RST_S), .bus(bus_s));

  exp_t          exp_q[$];
  logic [SW-1:0] model_cnt;
  bit            model_halted;
  int            n_checks;
  int            n_fail;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  function automatic step_t mk(input logic rst, ihit, dhit, mren, mwen, exren,
                               input logic [4:0] wreg, rs, rt,
                               input logic usert, redir, whalt,
                               input ctrl_t c, input logic h);
    step_t s;
    s.rst = rst;   s.ihit = ihit;   s.dhit = dhit;
    s.mren = mren; s.mwen = mwen;   s.exren = exren;
    s.wreg = wreg; s.rs = rs;       s.rt = rt;
    s.usert = usert; s.redir = redir; s.whalt = whalt;
    s.c = c;       s.h = h;
    return s;
  endfunction

  function automatic ctrl_t obs();
    return {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen, bus.memwb_wen,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush,
            bus.imemREN};
  endfunction

  // Drive one cycle of stimulus and queue what the controller must produce
  task automatic apply(input step_t s);
    exp_t e;
    RST            = s.rst;
    bus.ihit       = s.ihit;
    bus.dhit       = s.dhit;
    bus.mem_ren    = s.mren;
    bus.mem_wen    = s.mwen;
    bus.ex_ren     = s.exren;
    bus.ex_wreg    = s.wreg;
    bus.id_rs      = s.rs;
    bus.id_rt      = s.rt;
    bus.id_uses_rt = s.usert;
    bus.redirect   = s.redir;
    bus.wb_halt    = s.whalt;
    if (s.rst) begin
      model_cnt    = '0;
      model_halted = 1'b0;
    end else begin
      if (!model_halted && !s.c[9] && (model_cnt != {SW{1'b1}}))
        model_cnt = model_cnt + SW'(1);
      if (s.h) model_halted = 1'b1;
    end
    e.ctrl = s.c;
    e.halt = s.rst ? 1'b0 : s.h;
    e.cnt  = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(1,1,0,0,0,0, 0,0,0, 0,0,0, C_RST, 0));
    steps.push_back(mk(1,1,0,1,1,1, 5,5,5, 1,1,1, C_RST, 0));
    steps.push_back(mk(1,0,0,1,0,0, 0,0,0, 0,0,0, C_RST, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) begin
        n_fail++;
        $display("FAIL reset[%0d] ctrl got %b exp %b", i, obs(), e.ctrl);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (bus.halt !== e.halt) begin
        n_fail++;
        $display("FAIL reset[%0d] halt got %b exp %b", i, bus.halt, e.halt);
      end
      n_checks++;
      if (bus.stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL reset[%0d] stall_count got %0d exp %0d", i, bus.stall_count, e.cnt);
      end
    end
  endtask

  task automatic test_run();
    step_t steps[$];
    exp_t  e;
    for (int k = 0; k < 4; k++)
      steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN, 0));
    steps.push_back(mk(0,1,0,0,0,1, 5,3,5, 0,0,0, C_RUN, 0));
    steps.push_back(mk(0,1,0,0,0,0, 5,5,5, 1,0,0, C_RUN, 0));
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) begin
        n_fail++;
        $display("FAIL run[%0d] ctrl got %b exp %b", i, obs(), e.ctrl);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (bus.halt !== e.halt) begin
        n_fail++;
        $display("FAIL run[%0d] halt got %b exp %b", i, bus.halt, e.halt);
      end
      n_checks++;
      if (bus.stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL run[%0d] stall_count got %0d exp %0d", i, bus.stall_count, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(0,1,0,0,0,1, 5,5,0, 0,0,0, C_LUSE,    0));
    steps.push_back(mk(0,1,0,0,0,1, 0,0,0, 0,0,0, C_RUN,     0));
    steps.push_back(mk(0,1,0,0,0,1, 7,2,7, 1,0,0, C_LUSE,    0));
    steps.push_back(mk(0,1,0,0,0,1, 7,2,7, 0,0,0, C_RUN,     0));
    steps.push_back(mk(0,0,0,0,0,1, 9,9,0, 0,0,0, C_LUSE,    0));
    for (int k = 0; k < 3; k++)
      steps.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,0, C_IMISS, 0));
    steps.push_back(mk(0,1,0,0,0,1, 4,4,0, 0,1,0, C_REDIR_R, 0));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN,     0));
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) begin
        n_fail++;
        $display("FAIL load_use[%0d] ctrl got %b exp %b", i, obs(), e.ctrl);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (bus.halt !== e.halt) begin
        n_fail++;
        $display("FAIL load_use[%0d] halt got %b exp %b", i, bus.halt, e.halt);
      end
      n_checks++;
      if (bus.stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL load_use[%0d] stall_count got %0d exp %0d", i, bus.stall_count, e.cnt);
      end
    end
  endtask

  task automatic test_dwait();
    step_t steps[$];
    exp_t  e;
    for (int k = 0; k < 3; k++)
      steps.push_back(mk(0,1,0,1,0,0, 0,0,0, 0,0,0, C_DFRZ, 0));
    steps.push_back(mk(0,1,1,1,0,0, 0,0,0, 0,0,0, C_DHIT,    0));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN,     0));
    steps.push_back(mk(0,1,0,0,1,0, 0,0,0, 0,0,0, C_DFRZ,    0));
    steps.push_back(mk(0,0,1,0,1,0, 0,0,0, 0,0,0, C_IMISS_D, 0));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN,     0));
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) begin
        n_fail++;
        $display("FAIL dwait[%0d] ctrl got %b exp %b", i, obs(), e.ctrl);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (bus.halt !== e.halt) begin
        n_fail++;
        $display("FAIL dwait[%0d] halt got %b exp %b", i, bus.halt, e.halt);
      end
      n_checks++;
      if (bus.stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL dwait[%0d] stall_count got %0d exp %0d", i, bus.stall_count, e.cnt);
      end
    end
  endtask

  task automatic test_redirect_wait();
    step_t steps[$];
    exp_t  e;
    for (int k = 0; k < 2; k++)
      steps.push_back(mk(0,1,0,0,1,0, 0,0,0, 0,1,0, C_DFRZ, 0));
    steps.push_back(mk(0,1,1,0,1,0, 0,0,0, 0,1,0, C_REDIR_D, 0));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN,     0));
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) begin
        n_fail++;
        $display("FAIL redirect_wait[%0d] ctrl got %b exp %b", i, obs(), e.ctrl);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (bus.halt !== e.halt) begin
        n_fail++;
        $display("FAIL redirect_wait[%0d] halt got %b exp %b", i, bus.halt, e.halt);
      end
      n_checks++;
      if (bus.stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL redirect_wait[%0d] stall_count got %0d exp %0d", i, bus.stall_count, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(0,1,0,0,0,1, 5,5,0, 0,0,1, C_HFL_R, 1));
    for (int k = 0; k < 10; k++)
      steps.push_back(mk(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                         1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom), C_HALTED, 1));
    steps.push_back(mk(1,1,0,0,0,0, 0,0,0, 0,0,0, C_RST,    0));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN,    0));
    steps.push_back(mk(0,1,0,1,0,0, 0,0,0, 0,0,1, C_HFL_D,  1));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_HALTED, 1));
    steps.push_back(mk(1,1,0,0,0,0, 0,0,0, 0,0,0, C_RST,    0));
    steps.push_back(mk(0,1,0,1,0,0, 0,0,0, 0,0,0, C_DFRZ,   0));
    steps.push_back(mk(1,1,0,1,0,0, 0,0,0, 0,0,0, C_RST,    0));
    steps.push_back(mk(0,1,0,0,0,0, 0,0,0, 0,0,0, C_RUN,    0));
    foreach (steps[i]) begin
      apply(steps[i]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) begin
        n_fail++;
        $display("FAIL halt[%0d] ctrl got %b exp %b", i, obs(), e.ctrl);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (bus.halt !== e.halt) begin
        n_fail++;
        $display("FAIL halt[%0d] halt got %b exp %b", i, bus.halt, e.halt);
      end
      n_checks++;
      if (bus.stall_count !== e.cnt) begin
        n_fail++;
        $display("FAIL halt[%0d] stall_count got %0d exp %0d", i, bus.stall_count, e.cnt);
      end
    end
  endtask

  // Narrow counter instance: held ihit=0 must saturate at 15, never wrap
  task automatic test_saturation();
    logic [SW_S-1:0] cnt_q[$];
    logic [SW_S-1:0] want;
    RST   = 1'b1;
    RST_S = 1'b1;
    cnt_q.push_back('0);
    @(posedge CLK); #1;
    want = cnt_q.pop_front();
    n_checks++;
    if (bus_s.stall_count !== want) begin
      n_fail++;
      $display("FAIL saturation reset stall_count got %0d exp %0d", bus_s.stall_count, want);
    end
    RST_S      = 1'b0;
    bus_s.ihit = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cnt_q.push_back((k > 15) ? SW_S'(15) : SW_S'(k));
      @(posedge CLK); #1;
      want = cnt_q.pop_front();
      n_checks++;
      if (bus_s.stall_count !== want) begin
        n_fail++;
        $display("FAIL saturation[%0d] stall_count got %0d exp %0d", k, bus_s.stall_count, want);
      end
    end
    n_checks++;
    if (bus_s.pc_wen !== 1'b0 || bus_s.ifid_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation ctrl pc_wen=%b ifid_flush=%b exp 0/1", bus_s.pc_wen, bus_s.ifid_flush);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    model_cnt    = '0;
    model_halted = 1'b0;
    RST   = 1'b1;
    RST_S = 1'b1;
    bus.ihit = 1'b0; bus.dhit = 1'b0; bus.mem_ren = 1'b0; bus.mem_wen = 1'b0;
    bus.ex_ren = 1'b0; bus.ex_wreg = '0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rt = 1'b0; bus.redirect = 1'b0; bus.wb_halt = 1'b0;
    bus_s.ihit = 1'b0; bus_s.dhit = 1'b0; bus_s.mem_ren = 1'b0; bus_s.mem_wen = 1'b0;
    bus_s.ex_ren = 1'b0; bus_s.ex_wreg = '0; bus_s.id_rs = '0; bus_s.id_rt = '0;
    bus_s.id_uses_rt = 1'b0; bus_s.redirect = 1'b0; bus_s.wb_halt = 1'b0;
    @(posedge CLK); #1;

    test_reset();
    test_run();
    test_load_use();
    test_dwait();
    test_redirect_wait();
    test_halt();
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage pipeline. It generates the write-enable and flush controls for the PC and the four pipeline registers (ifid, idex, exmem, memwb). It arbitrates the shared memory port between instruction fetch and the data access in MEM, and latches processor halt. It sits beside the datapath: it consumes decode, EX and MEM stage fields, and its outputs drive the `writeEN`/`flush` inputs of each pipeline register for the next clock edge.

## Interface
- `STALL_W`, default 16: width of the saturating stall-cycle counter.
- `CLK` in 1: clock, all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ihit` in 1: instruction fetch completes this cycle.
- `dhit` in 1: data access completes this cycle.
- `mem_ren`, `mem_wen` in 1: exmem `dMemREN_out` / `dMemWEN_out` (access in MEM).
- `ex_ren` in 1: idex `dMemREN_out` (load in EX).
- `ex_wreg` in 5: idex `writeReg_out`.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `redirect` in 1: taken branch, jump or jr resolved in MEM (from exmem PcSrc/JType/JReg outputs).
- `wb_halt` in 1: memwb `Halt_out`.
- `pc_wen` out 1: PC register write enable.
- `ifid_wen`, `idex_wen`, `exmem_wen`, `memwb_wen` out 1: pipeline register write enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: pipeline register flushes.
- `imemREN` out 1: instruction-fetch request to the shared memory port.
- `halt` out 1: registered halt flag.
- `stall_count` out `STALL_W`: cycles with `pc_wen`=0 outside HALT.

## Operation
- FSM states: RUN, DWAIT, HALT. Outputs are combinational from state and inputs (Mealy). State, `halt` and `stall_count` are registered.
- `dpend` = `mem_ren` | `mem_wen`. `luse` = `ex_ren` & `ex_wreg`≠0 & (`ex_wreg`==`id_rs` | (`id_uses_rt` & `ex_wreg`==`id_rt`)).
- Default for every output is wen=0 and flush=0.
- RUN and DWAIT use the same priority list (first match wins):
  1. `wb_halt`: flush ifid, idex and exmem; all wen=0; next state HALT.
  2. `dpend` & ~`dhit`: freeze PC, ifid, idex and exmem (wen=0, no flush); `memwb_flush`=1; next state DWAIT.
  3. `redirect`: `pc_wen`=1 (datapath loads the target); flush ifid, idex and exmem; `memwb_wen`=1; next state RUN.
  4. `luse`: `pc_wen`=0, `ifid_wen`=0, `idex_flush`=1, `exmem_wen`=1, `memwb_wen`=1.
  5. ~`ihit`: `pc_wen`=0, `ifid_flush`=1; idex, exmem and memwb wen=1.
  6. Otherwise: all five wen=1.
- Arbitration: `imemREN`=1 only in RUN with `dpend`=0. Data always wins the port, and `imemREN`=0 in DWAIT and HALT.
- HALT is absorbing until `RST`. In HALT: all wen=0, all flush=0 (pipeline contents held), `imemREN`=0, `halt`=1.
- `stall_count` increments in RUN/DWAIT when `pc_wen`=0 and saturates at all-ones.

## Timing
- Reset (`RST`=1 at an edge): next state RUN, `halt`=0, `stall_count`=0.
- While `RST`=1, outputs are forced to: all flush=1, all wen=0, `pc_wen`=0, `imemREN`=0. Reset asserted mid-DWAIT or in HALT behaves identically.
- Control latency is 0 cycles: outputs act at the next edge in the pipeline registers.
- `halt` rises on the edge after `wb_halt` is seen in RUN/DWAIT.
- DWAIT exits in the same cycle `dhit`=1 is seen: priorities 3–6 apply that cycle, and the state is RUN at the next edge.
- Simultaneous events:
  - `redirect` with pending data access and ~`dhit`: wait first (priority 2); the redirect is applied on the `dhit` cycle because exmem is frozen and `redirect` persists.
  - `redirect` with `luse`: redirect wins, and the idex flush removes the hazard.
  - `luse` with ~`ihit`: load-use rule applies; ifid is held, not flushed.
  - `wb_halt` with a pending data access: halt wins.
- Counter wrap: none. The counter holds at 2^`STALL_W`−1.

## Test plan
- Reset, then ihit=1 with no hazards for 4 cycles: all wen=1, no flush, `imemREN`=1, `stall_count`=0.
- `ex_ren`=1, `ex_wreg`=5, `id_rs`=5, ihit=1: one cycle with `pc_wen`=0, `ifid_wen`=0, `idex_flush`=1, `exmem_wen`=1. Same stimulus with `ex_wreg`=0: no stall.
- `mem_ren`=1, dhit=0 for 3 cycles, then dhit=1: state DWAIT for 3 cycles with IF..EX/MEM frozen, `memwb_flush`=1 and `imemREN`=0. On the dhit cycle all wen=1. `stall_count`=3.
- `redirect`=1 and `mem_wen`=1 with dhit=0 for 2 cycles, then dhit=1: frozen for 2 cycles, then `pc_wen`=1 with ifid, idex and exmem flushed.
- `wb_halt`=1 while `luse`=1: flushes that cycle, `halt`=1 next edge, then all wen=0 and `imemREN`=0 for 10 cycles. `RST` pulse returns to RUN with `halt`=0.
- Force `STALL_W`=4 and hold ihit=0 for 20 cycles: `stall_count` saturates at 15.
